// File: rtl/light_pkg.sv
// light_pkg: shared types and defaults for the turn-signal input conditioning path.
package light_pkg;
    typedef enum logic {HZ_OFF = 1'b0, HZ_ON = 1'b1} hz_state_t;
    localparam int DB_CYCLES_DEF = 16;
endpackage

// File: rtl/turn_signal_input_ctrl_if.sv
// turn_signal_input_ctrl_if: raw driver controls in, clean sequencer requests out.
interface turn_signal_input_ctrl_if;
    logic LeverL_raw;
    logic LeverR_raw;
    logic HazBtn_raw;
    logic Left;
    logic Right;
    logic Haz;
    modport master (output LeverL_raw, LeverR_raw, HazBtn_raw, input Left, Right, Haz);
    modport slave (input LeverL_raw, LeverR_raw, HazBtn_raw, output Left, Right, Haz);
endinterface

// File: rtl/input_debounce.sv
// input_debounce: two-flop synchroniser plus stable-count debounce with a registered rising-edge pulse.
module input_debounce
    import light_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    localparam int DB_W = $clog2(DB_CYCLES + 1)
) (
    input  logic Clk,
    input  logic Rst,
    input  logic raw_in,
    output logic db_out,
    output logic rise_pulse
);
    logic [1:0] sync;
    logic [DB_W-1:0] cnt;
    logic done;
    // The accepting edge is the DB_CYCLES-th consecutive cycle of disagreement.
    assign done = (sync[1] != db_out) && (cnt == DB_W'(DB_CYCLES - 1));
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            sync <= '0;
            cnt <= '0;
            db_out <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync <= {sync[0], raw_in};
            cnt <= (sync[1] == db_out || done) ? '0 : cnt + 1'b1;
            db_out <= done ? sync[1] : db_out;
            rise_pulse <= done & sync[1];
        end
endmodule

// File: rtl/turn_signal_input_ctrl.sv
// turn_signal_input_ctrl: debounced lever/hazard conditioning feeding the tail-light sequencer.
// Optional LEVER_CANCELS_HAZ_EN: a fresh single-lever push cancels an active hazard.
module turn_signal_input_ctrl
    import light_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input logic Clk,
    input logic Rst,
    turn_signal_input_ctrl_if.slave bus
);
    logic db_l, db_r, db_h;
    logic rise_l, rise_r, rise_h;
    logic cancel, haz_req;
    hz_state_t hz, hz_next;
    input_debounce #(.DB_CYCLES(DB_CYCLES)) u_left (
        .Clk(Clk), .Rst(Rst), .raw_in(bus.LeverL_raw), .db_out(db_l), .rise_pulse(rise_l)
    );
    input_debounce #(.DB_CYCLES(DB_CYCLES)) u_right (
        .Clk(Clk), .Rst(Rst), .raw_in(bus.LeverR_raw), .db_out(db_r), .rise_pulse(rise_r)
    );
    input_debounce #(.DB_CYCLES(DB_CYCLES)) u_haz (
        .Clk(Clk), .Rst(Rst), .raw_in(bus.HazBtn_raw), .db_out(db_h), .rise_pulse(rise_h)
    );
`ifdef LEVER_CANCELS_HAZ_EN
    assign cancel = (rise_l & ~db_r) | (rise_r & ~db_l);
`else
    logic unused_rise;
    assign unused_rise = rise_l ^ rise_r ^ db_h;
    assign cancel = 1'b0;
`endif
    // A button toggle outranks a lever cancel in the same cycle.
    always_comb hz_next = rise_h ? (hz == HZ_ON ? HZ_OFF : HZ_ON) : (cancel ? HZ_OFF : hz);
    assign haz_req = (db_l & db_r) | (hz_next == HZ_ON);
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            hz <= HZ_OFF;
            bus.Left <= 1'b0;
            bus.Right <= 1'b0;
            bus.Haz <= 1'b0;
        end else begin
            hz <= hz_next;
            bus.Left <= db_l & ~haz_req;
            bus.Right <= db_r & ~haz_req;
            bus.Haz <= haz_req;
        end
endmodule

// File: tb/tb_turn_signal_input_ctrl.sv
// tb_turn_signal_input_ctrl: directed checks with DB_CYCLES=4 (raw edge to output = 7 edges).
module tb_turn_signal_input_ctrl;
    logic Clk;
    logic Rst;
    int checks = 0;
    int errors = 0;
    logic [2:0] got;
    turn_signal_input_ctrl_if bus ();
    turn_signal_input_ctrl #(.DB_CYCLES(4)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (!Rst) begin
            checks++;
            if ($countones({bus.Left, bus.Right, bus.Haz}) > 1) begin
                errors++;
                $display("FAIL onehot got LRH=%b%b%b want at most one high", bus.Left, bus.Right, bus.Haz);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        bus.LeverL_raw = 1'b1;
        bus.LeverR_raw = 1'b1;
        bus.HazBtn_raw = 1'b1;
        #1;
        got = {bus.Left, bus.Right, bus.Haz};
        checks++;
        if (got !== 3'b000) begin errors++; $display("FAIL reset_async got %b want 000", got); end
        step(3);
        got = {bus.Left, bus.Right, bus.Haz};
        checks++;
        if (got !== 3'b000) begin errors++; $display("FAIL reset_held got %b want 000", got); end
        Rst = 1'b0;
        bus.LeverR_raw = 1'b0;
        bus.HazBtn_raw = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            got = {bus.Left, bus.Right, bus.Haz};
            checks++;
            if (got !== (e == 7 ? 3'b100 : 3'b000)) begin
                errors++;
                $display("FAIL reset_release_left edge=%0d got %b want %b", e, got, e == 7 ? 3'b100 : 3'b000);
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        pat = 6'b101101;
        bus.LeverL_raw = 1'b0;
        step(10);
        got = {bus.Left, bus.Right, bus.Haz};
        checks++;
        if (got !== 3'b000) begin errors++; $display("FAIL bounce_idle got %b want 000", got); end
        for (int e = 1; e <= 14; e++) begin
            bus.LeverL_raw = (e <= 6) ? pat[6-e] : 1'b1;
            step(1);
            checks++;
            if (bus.Left !== (e >= 12)) begin
                errors++;
                $display("FAIL bounce_left edge=%0d got %b want %b", e, bus.Left, e >= 12);
            end
        end
    endtask

    task automatic test_hazard();
        bus.LeverL_raw = 1'b0;
        step(10);
        bus.HazBtn_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            got = {bus.Left, bus.Right, bus.Haz};
            checks++;
            if (got !== (e >= 7 ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL haz_on edge=%0d got %b want %b", e, got, e >= 7 ? 3'b001 : 3'b000);
            end
        end
        bus.HazBtn_raw = 1'b0;
        step(10);
        got = {bus.Left, bus.Right, bus.Haz};
        checks++;
        if (got !== 3'b001) begin errors++; $display("FAIL haz_release_hold got %b want 001", got); end
        bus.HazBtn_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            got = {bus.Left, bus.Right, bus.Haz};
            checks++;
            if (got !== (e >= 7 ? 3'b000 : 3'b001)) begin
                errors++;
                $display("FAIL haz_off edge=%0d got %b want %b", e, got, e >= 7 ? 3'b000 : 3'b001);
            end
        end
        bus.HazBtn_raw = 1'b0;
        step(10);
        got = {bus.Left, bus.Right, bus.Haz};
        checks++;
        if (got !== 3'b000) begin errors++; $display("FAIL haz_off_release got %b want 000", got); end
    endtask

    task automatic test_fault();
        bus.LeverL_raw = 1'b1;
        bus.LeverR_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            got = {bus.Left, bus.Right, bus.Haz};
            checks++;
            if (got !== (e == 7 ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL fault_on edge=%0d got %b want %b", e, got, e == 7 ? 3'b001 : 3'b000);
            end
        end
        step(5);
        bus.LeverR_raw = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            got = {bus.Left, bus.Right, bus.Haz};
            checks++;
            if (got !== (e == 7 ? 3'b100 : 3'b001)) begin
                errors++;
                $display("FAIL fault_clear edge=%0d got %b want %b", e, got, e == 7 ? 3'b100 : 3'b001);
            end
        end
        bus.LeverL_raw = 1'b0;
        step(10);
        got = {bus.Left, bus.Right, bus.Haz};
        checks++;
        if (got !== 3'b000) begin errors++; $display("FAIL fault_idle got %b want 000", got); end
    endtask

    task automatic test_reset_mid();
        bus.HazBtn_raw = 1'b1;
        step(10);
        bus.HazBtn_raw = 1'b0;
        bus.LeverR_raw = 1'b1;
        step(10);
        got = {bus.Left, bus.Right, bus.Haz};
        checks++;
        if (got !== 3'b001) begin errors++; $display("FAIL mid_haz_lever got %b want 001", got); end
        Rst = 1'b1;
        #1;
        got = {bus.Left, bus.Right, bus.Haz};
        checks++;
        if (got !== 3'b000) begin errors++; $display("FAIL mid_reset_async got %b want 000", got); end
        step(1);
        Rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            got = {bus.Left, bus.Right, bus.Haz};
            checks++;
            if (got !== (e == 7 ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL mid_reset_right edge=%0d got %b want %b", e, got, e == 7 ? 3'b010 : 3'b000);
            end
        end
    endtask

    task automatic test_lever_cancel();
        logic [2:0] want;
        bus.LeverR_raw = 1'b0;
        step(10);
        bus.HazBtn_raw = 1'b1;
        step(10);
        bus.HazBtn_raw = 1'b0;
        step(10);
        got = {bus.Left, bus.Right, bus.Haz};
        checks++;
        if (got !== 3'b001) begin errors++; $display("FAIL cancel_setup got %b want 001", got); end
        bus.LeverL_raw = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step(1);
`ifdef LEVER_CANCELS_HAZ_EN
            want = (e >= 7) ? 3'b100 : 3'b001;
`else
            want = 3'b001;
`endif
            got = {bus.Left, bus.Right, bus.Haz};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL lever_cancel edge=%0d got %b want %b", e, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_hazard();
        test_fault();
        test_reset_mid();
        test_lever_cancel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/turn_signal_input_ctrl.md
Name: turn_signal_input_ctrl

Overview:
- Input conditioning stage that sits directly upstream of the tail-light sequencer FSM.
- Takes raw, asynchronous, bouncy driver controls: turn lever left, turn lever right, and a hazard push-button.
- Produces clean, registered, mutually exclusive Left/Right/Haz levels that drive the sequencer's Left, Right and Haz inputs.
- Hazard is a push-on/push-off latch; the lever is a level control.

Parameters:
- DB_CYCLES, 16: consecutive stable cycles required to accept a new input level. Legal range is 1 or more.
- DB_W, $clog2(DB_CYCLES+1): debounce counter width. Derived; not overridden.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- LeverL_raw  in  1  raw left-lever contact, asynchronous.
- LeverR_raw  in  1  raw right-lever contact, asynchronous.
- HazBtn_raw  in  1  raw hazard push-button, asynchronous, high while pressed.
- Left  out  1  registered left-turn request to sequencer.
- Right  out  1  registered right-turn request to sequencer.
- Haz  out  1  registered hazard request to sequencer.

Behaviour:
Reset
- While Rst=1: Left=Right=Haz=0, all sync flops 0, debounced levels 0, counters 0, hazard latch HZ_OFF.
- Rst asserted mid-operation clears the hazard latch immediately.
- After release, inputs must re-qualify through full debounce.

Synchroniser
- Two-flop synchroniser per raw input.

Debounce (per input)
- If the synced value differs from the debounced value, the counter increments. Otherwise the counter clears to 0.
- When the counter reaches DB_CYCLES, the debounced value takes the synced value and the counter clears.
- Any glitch shorter than DB_CYCLES cycles is rejected.

Hazard latch (FSM, states HZ_OFF and HZ_ON)
- A rising edge of debounced HazBtn toggles the state.
- Falling edge: no effect.
- Holding the button keeps the state; it does not re-toggle.

Output logic (registered, one cycle after debounced/latch update)
- Lever fault (dbL=1 and dbR=1): Haz=1, Left=0, Right=0 while the fault persists. The hazard latch itself is unaffected.
- Else if HZ_ON: Haz=1, Left=0, Right=0.
- Else: Left=dbL, Right=dbR, Haz=0.

Invariant
- At most one of Left, Right, Haz is 1 in any cycle.

Latency
- Raw edge to output = 2 sync + DB_CYCLES debounce + 1 output register.
- With DB_CYCLES=16 that is 19 Clk edges, counting the first edge after the raw change as edge 1.

Simultaneous events
- Hazard toggle and a lever change in the same cycle: hazard priority applies to that cycle's output.
- Lever release during HZ_ON: outputs unchanged (Haz=1).
- Hazard off while lever held: Left or Right resumes on the next registered cycle.

Optional Feature:
- Macro: LEVER_CANCELS_HAZ_EN.
- Defined: a rising edge of debounced LeverL or LeverR, when the other lever is 0, forces the latch HZ_ON to HZ_OFF. The output then follows the lever next cycle. If the same cycle also has a hazard rising edge, the toggle wins.
- Undefined: the lever never affects the hazard latch; only the button clears it.

Decomposition:
- Shared package (light_pkg):
  - hazard state enum HZ_OFF=1'b0, HZ_ON=1'b1;
  - default DB_CYCLES constant.
- Sub-module input_debounce:
  - parameter DB_CYCLES; ports Clk, Rst, raw_in, db_out, rise_pulse;
  - contains the synchroniser and debounce counter;
  - instantiated three times.
- The top holds the hazard FSM, fault logic and output registers.

Test Plan (DB_CYCLES=4, latency 7 edges):
- Rst=1 with all raw inputs =1 → Left=Right=Haz=0. Release Rst with LeverL_raw held 1 → Left=1 at edge 7, Right=Haz=0.
- LeverL_raw bounce pattern 1,0,1,1,0,1 (cycles) then steady 1 → no Left change until 4 consecutive stable synced cycles. No glitch ever appears on Left.
- HazBtn pressed 10 cycles, released, pressed again 10 cycles → Haz=1 at edge 7 after the first press. Haz stays 1 through the release. Haz returns to 0 seven edges after the second press.
- LeverL_raw=1 and LeverR_raw=1 together → Haz=1, Left=Right=0 at edge 7. Drop LeverR_raw → Left=1, Haz=0 seven edges later, with the hazard latch still HZ_OFF.
- With HZ_ON and LeverR held, assert Rst for 1 cycle then release → Haz=0 immediately. Right=1 at edge 7 after release.
- LEVER_CANCELS_HAZ_EN defined, HZ_ON, LeverL_raw 0→1 → Haz drops and Left=1 at edge 7. Undefined, same stimulus → Haz stays 1, Left=0.
